// File: rtl/branch_resolve_pkg.sv
// Shared definitions for branch_resolve: condition codes, FSM encoding, PC step default.
// The helper picks the comparator bit selected by a condition code.
package branch_resolve_pkg;

  localparam int PC_STEP_DEFAULT = 4;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NEQ    = 3'd2,
    COND_LT     = 3'd3,
    COND_LEQ    = 3'd4,
    COND_ZERO   = 3'd5,
    COND_NZ     = 3'd6,
    COND_LZ     = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  function automatic logic cond_taken(input logic [7:0] cmp_res, input cond_e c);
    return cmp_res[c];
  endfunction

endpackage

// File: rtl/branch_resolve_stats.sv
// Saturating branch / mispredict event counters (present only with BRANCH_RESOLVE_STATS_EN).
// Latency: count visible one cycle after the event; no backpressure, counters never wrap.
module branch_resolve_stats (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_branch,
  input  logic        inc_mispredict,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (inc_branch && stat_branches != '1)
        stat_branches <= stat_branches + 32'd1;
      if (inc_mispredict && stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Resolves a branch descriptor into direction/next PC and raises a fetch redirect plus flush on mispredict.
// Latency 1 cycle; HOLD accepts only while draining, REDIRECT stalls until out_ready and redirect_ack seen. Optional stats: BRANCH_RESOLVE_STATS_EN.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_STEP = PC_STEP_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      cond,
  input  logic [7:0]      cmp_res,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_npc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ack,
  output logic            flush
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  state_e          state_q, state_d;
  logic            taken_q;
  logic [XLEN-1:0] npc_q;
  logic            flush_q;
  logic            ack_seen_q, ordy_seen_q;

  logic            taken, mispredict, accept;
  logic            ack_now, ordy_now;
  logic [XLEN-1:0] npc;

  assign taken      = cond_taken(cmp_res, cond_e'(cond));
  assign npc        = taken ? target : pc + XLEN'(PC_STEP);
  assign mispredict = taken != pred_taken;
  assign accept     = in_valid & in_ready;

  // Each REDIRECT handshake counts once, whichever side completes first.
  assign ack_now  = ack_seen_q | redirect_ack;
  assign ordy_now = ordy_seen_q | out_ready;

  always_comb begin
    state_d        = state_q;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_d = mispredict ? ST_REDIRECT : ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (!in_valid)
            state_d = ST_IDLE;
          else
            state_d = mispredict ? ST_REDIRECT : ST_HOLD;
        end
      end
      ST_REDIRECT: begin
        out_valid      = !ordy_seen_q;
        redirect_valid = !ack_seen_q;
        if (ack_now && ordy_now)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      taken_q     <= 1'b0;
      npc_q       <= '0;
      flush_q     <= 1'b0;
      ack_seen_q  <= 1'b0;
      ordy_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      flush_q <= accept & mispredict;
      if (accept) begin
        taken_q <= taken;
        npc_q   <= npc;
      end
      if (state_q == ST_REDIRECT && state_d == ST_REDIRECT) begin
        ack_seen_q  <= ack_now;
        ordy_seen_q <= ordy_now;
      end else begin
        ack_seen_q  <= 1'b0;
        ordy_seen_q <= 1'b0;
      end
    end
  end

  assign out_taken   = taken_q;
  assign out_npc     = npc_q;
  assign redirect_pc = npc_q;
  assign flush       = flush_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  branch_resolve_stats u_stats (
    .clk              (clk),
    .rst_n            (rst_n),
    .inc_branch       (accept),
    .inc_mispredict   (accept & mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );
`endif

endmodule
